// File: rtl/ex_alu_issue.sv
// ex_alu_issue: execute-stage front end around an external combinational ALU.
//
// An instruction from ID is decoded and registered into the issue stage (S1).
// S1 drives the ALU control and operands directly. The ALU result and zero
// flag are captured into the result stage (S2), which feeds MEM/WB.
// Both stages use valid/ready flow control, so the block sustains one op per
// cycle and holds at most two entries under backpressure.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid / in_ready            ID handshake
//   opcode, funct3, funct7b5       RV32I encoding fields
//   rs1_data, rs2_data, imm        operand sources
//   tag_in                         destination tag, passed through unchanged
//   alu_ctr, alu_a, alu_b          to ALU (AND=00, OR=01, ADD=10, SUB=11)
//   alu_out, alu_zero              from ALU, combinational on alu_*
//   out_valid / out_ready          MEM/WB handshake
//   result, br_taken, is_branch,
//   illegal, tag_out               registered S2 outputs
module ex_alu_issue #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  imm,
  input  logic [TAG_W-1:0] tag_in,
  output logic [1:0]       alu_ctr,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  input  logic [XLEN-1:0]  alu_out,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic             br_taken,
  output logic             is_branch,
  output logic             illegal,
  output logic [TAG_W-1:0] tag_out
);

  localparam logic [1:0] CTR_AND = 2'b00;
  localparam logic [1:0] CTR_OR  = 2'b01;
  localparam logic [1:0] CTR_ADD = 2'b10;
  localparam logic [1:0] CTR_SUB = 2'b11;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  // Decoded fields of the instruction currently offered by ID
  logic [1:0]      w_dec_ctr;
  logic [XLEN-1:0] w_dec_a;
  logic [XLEN-1:0] w_dec_b;
  logic            w_dec_br;
  logic            w_dec_bne;
  logic            w_dec_ill;

  // Issue stage
  logic             r_s1_valid;
  logic [1:0]       r_s1_ctr;
  logic [XLEN-1:0]  r_s1_a;
  logic [XLEN-1:0]  r_s1_b;
  logic             r_s1_br;
  logic             r_s1_bne;
  logic             r_s1_ill;
  logic [TAG_W-1:0] r_s1_tag;

  // Result stage
  logic             r_s2_valid;
  logic [XLEN-1:0]  r_s2_result;
  logic             r_s2_taken;
  logic             r_s2_br;
  logic             r_s2_ill;
  logic [TAG_W-1:0] r_s2_tag;

  logic w_s2_adv;
  logic w_s1_adv;
  logic w_accept;

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign w_accept = in_valid && w_s1_adv;
  assign in_ready = w_s1_adv;

  always_comb begin
    w_dec_ctr = CTR_ADD;
    w_dec_a   = rs1_data;
    w_dec_b   = '0;
    w_dec_br  = 1'b0;
    w_dec_bne = 1'b0;
    w_dec_ill = 1'b0;
    case (opcode)
      OP_R, OP_I: begin
        w_dec_b = (opcode == OP_R) ? rs2_data : imm;
        case (funct3)
          3'b000:  w_dec_ctr = (opcode == OP_R && funct7b5) ? CTR_SUB : CTR_ADD;
          3'b110:  w_dec_ctr = CTR_OR;
          3'b111:  w_dec_ctr = CTR_AND;
          default: w_dec_ill = 1'b1;
        endcase
      end
      OP_LD, OP_ST: begin
        w_dec_b = imm;
      end
      OP_BR: begin
        w_dec_ctr = CTR_SUB;
        w_dec_b   = rs2_data;
        case (funct3)
          3'b000:  w_dec_br = 1'b1;
          3'b001: begin
            w_dec_br  = 1'b1;
            w_dec_bne = 1'b1;
          end
          default: w_dec_ill = 1'b1;
        endcase
      end
      default: w_dec_ill = 1'b1;
    endcase
    // Unsupported encodings travel as a harmless 0 + 0 so the ALU stays quiet
    if (w_dec_ill) begin
      w_dec_ctr = CTR_ADD;
      w_dec_a   = '0;
      w_dec_b   = '0;
      w_dec_br  = 1'b0;
      w_dec_bne = 1'b0;
    end
  end

  // Data registers only load on a real transfer so that alu_* and the S2
  // outputs stay frozen while the pipe is stalled or empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_ctr   <= CTR_ADD;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_br    <= 1'b0;
      r_s1_bne   <= 1'b0;
      r_s1_ill   <= 1'b0;
      r_s1_tag   <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_ctr <= w_dec_ctr;
        r_s1_a   <= w_dec_a;
        r_s1_b   <= w_dec_b;
        r_s1_br  <= w_dec_br;
        r_s1_bne <= w_dec_bne;
        r_s1_ill <= w_dec_ill;
        r_s1_tag <= tag_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_taken  <= 1'b0;
      r_s2_br     <= 1'b0;
      r_s2_ill    <= 1'b0;
      r_s2_tag    <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_result <= r_s1_ill ? '0 : alu_out;
        // BEQ takes on zero, BNE on non-zero
        r_s2_taken  <= r_s1_br && (alu_zero ^ r_s1_bne);
        r_s2_br     <= r_s1_br;
        r_s2_ill    <= r_s1_ill;
        r_s2_tag    <= r_s1_tag;
      end
    end
  end

  assign alu_ctr   = r_s1_ctr;
  assign alu_a     = r_s1_a;
  assign alu_b     = r_s1_b;
  assign out_valid = r_s2_valid;
  assign result    = r_s2_result;
  assign br_taken  = r_s2_taken;
  assign is_branch = r_s2_br;
  assign illegal   = r_s2_ill;
  assign tag_out   = r_s2_tag;

endmodule

// File: tb/tb_ex_alu_issue.sv
module tb_ex_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic        funct7b5 = 1'b0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [31:0] imm = '0;
  logic [4:0]  tag_in = '0;
  logic [1:0]  alu_ctr;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        br_taken;
  logic        is_branch;
  logic        illegal;
  logic [4:0]  tag_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ex_alu_issue #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .tag_in(tag_in),
    .alu_ctr(alu_ctr), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .br_taken(br_taken), .is_branch(is_branch), .illegal(illegal),
    .tag_out(tag_out)
  );

  // Reference ALU the block drives
  always_comb begin
    case (alu_ctr)
      2'b00:   alu_out = alu_a & alu_b;
      2'b01:   alu_out = alu_a | alu_b;
      2'b10:   alu_out = alu_a + alu_b;
      default: alu_out = alu_a - alu_b;
    endcase
  end
  assign alu_zero = (alu_out == 32'd0);

  // Output monitor: a handshake seen at negedge completes on the next posedge
  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          at;
  } obs_t;
  obs_t got[$];

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got.push_back('{result, tag_out, cyc});
      $display("out: tag=%0d result=0x%08h cycle=%0d", tag_out, result, cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] im;
    logic [4:0]  tag;
    logic [1:0]  ctr;
    logic [31:0] b;
    logic [31:0] res;
    logic        br;
    logic        isbr;
    logic        ill;
  } vec_t;

  vec_t vecs[13];

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [4:0] tg);
    opcode = op; funct3 = f3; funct7b5 = f7;
    rs1_data = a; rs2_data = b; imm = im; tag_in = tg;
    in_valid = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int acc;
    int k;
    int guard;
    logic [31:0] hold_res;
    logic [31:0] hold_a;

    // op, f3, f7, rs1, rs2, imm, tag, ctr, b, result, br, isbr, ill
    vecs[0]  = '{7'b0110011, 3'b000, 1'b0, 32'd5,        32'd7,      32'd0,        5'd1, 2'b10, 32'd7,      32'd12,       1'b0, 1'b0, 1'b0};
    vecs[1]  = '{7'b0110011, 3'b000, 1'b1, 32'd3,        32'd5,      32'd0,        5'd2, 2'b11, 32'd5,      32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{7'b0010011, 3'b000, 1'b0, 32'hFFFFFFFF, 32'd9,      32'd1,        5'd3, 2'b10, 32'd1,      32'd0,        1'b0, 1'b0, 1'b0};
    vecs[3]  = '{7'b1100011, 3'b000, 1'b0, 32'h1234,     32'h1234,   32'd0,        5'd4, 2'b11, 32'h1234,   32'd0,        1'b1, 1'b1, 1'b0};
    vecs[4]  = '{7'b1100011, 3'b001, 1'b0, 32'h1234,     32'h1234,   32'd0,        5'd5, 2'b11, 32'h1234,   32'd0,        1'b0, 1'b1, 1'b0};
    vecs[5]  = '{7'b1100011, 3'b001, 1'b0, 32'd1,        32'd2,      32'd0,        5'd6, 2'b11, 32'd2,      32'hFFFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{7'b0110011, 3'b110, 1'b0, 32'hF0,       32'h0F,     32'd0,        5'd7, 2'b01, 32'h0F,     32'hFF,       1'b0, 1'b0, 1'b0};
    vecs[7]  = '{7'b0010011, 3'b111, 1'b1, 32'hFF,       32'd0,      32'h0F,       5'd8, 2'b00, 32'h0F,     32'h0F,       1'b0, 1'b0, 1'b0};
    vecs[8]  = '{7'b0000011, 3'b010, 1'b0, 32'h1000,     32'd0,      32'hFFFFFFFC, 5'd9, 2'b10, 32'hFFFFFFFC, 32'hFFC,    1'b0, 1'b0, 1'b0};
    vecs[9]  = '{7'b0110011, 3'b001, 1'b0, 32'd5,        32'd3,      32'd0,        5'd10, 2'b10, 32'd0,     32'd0,        1'b0, 1'b0, 1'b1};
    vecs[10] = '{7'b1111111, 3'b000, 1'b0, 32'd9,        32'd9,      32'd9,        5'd11, 2'b10, 32'd0,     32'd0,        1'b0, 1'b0, 1'b1};
    vecs[11] = '{7'b1100011, 3'b100, 1'b0, 32'd1,        32'd2,      32'd0,        5'd12, 2'b10, 32'd0,     32'd0,        1'b0, 1'b0, 1'b1};
    vecs[12] = '{7'b0100011, 3'b010, 1'b0, 32'h10,       32'd77,     32'h8,        5'd13, 2'b10, 32'h8,     32'h18,       1'b0, 1'b0, 1'b0};

    // ---- reset state ----
    do_reset();
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst result", result, 32'd0);
    chk("rst flags", {29'd0, br_taken, is_branch, illegal}, 32'd0);
    chk("rst tag_out", {27'd0, tag_out}, 32'd0);
    chk("rst alu_ctr", {30'd0, alu_ctr}, 32'd2);
    chk("rst alu_a", alu_a, 32'd0);
    chk("rst alu_b", alu_b, 32'd0);

    // ---- single-op vectors, 2-cycle latency ----
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      drive(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].rs1, vecs[i].rs2, vecs[i].im, vecs[i].tag);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk($sformatf("v%0d alu_ctr", i), {30'd0, alu_ctr}, {30'd0, vecs[i].ctr});
      chk($sformatf("v%0d alu_a", i), alu_a, vecs[i].ill ? 32'd0 : vecs[i].rs1);
      chk($sformatf("v%0d alu_b", i), alu_b, vecs[i].b);
      chk($sformatf("v%0d early out_valid", i), {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d result", i), result, vecs[i].res);
      chk($sformatf("v%0d br_taken", i), {31'd0, br_taken}, {31'd0, vecs[i].br});
      chk($sformatf("v%0d is_branch", i), {31'd0, is_branch}, {31'd0, vecs[i].isbr});
      chk($sformatf("v%0d illegal", i), {31'd0, illegal}, {31'd0, vecs[i].ill});
      chk($sformatf("v%0d tag_out", i), {27'd0, tag_out}, {27'd0, vecs[i].tag});
    end
    repeat (2) @(posedge clk);
    #1;

    // ---- back-to-back stream of 8 ADDI ops ----
    got.delete();
    for (int i = 0; i < 8; i++) begin
      drive(7'b0010011, 3'b000, 1'b0, i, 32'd0, 32'd100, i[4:0]);
      @(negedge clk);
      chk($sformatf("stream in_ready %0d", i), {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("stream count", got.size(), 32'd8);
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      chk($sformatf("stream res %0d", i), got[i].res, 32'd100 + i);
      chk($sformatf("stream tag %0d", i), {27'd0, got[i].tag}, i);
      chk($sformatf("stream cycle %0d", i), got[i].at - got[0].at, i);
    end

    // ---- backpressure: out_ready low, offer 4 ops ----
    got.delete();
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      if (acc < 4) drive(7'b0010011, 3'b000, 1'b0, 32'd0, 32'd0, 32'd200 + acc, 5'(10 + acc));
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
    end
    chk("bp accepted", acc, 32'd2);
    chk("bp in_ready low", {31'd0, in_ready}, 32'd0);
    chk("bp out_valid", {31'd0, out_valid}, 32'd1);
    hold_res = result;
    hold_a   = alu_a;
    repeat (3) @(posedge clk);
    #1;
    chk("bp result stable", result, hold_res);
    chk("bp alu_a stable", alu_a, hold_a);
    chk("bp stalled result", hold_res, 32'd200);
    out_ready = 1'b1;
    guard = 0;
    while (acc < 4 && guard < 20) begin
      drive(7'b0010011, 3'b000, 1'b0, 32'd0, 32'd0, 32'd200 + acc, 5'(10 + acc));
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    chk("bp all accepted", acc, 32'd4);
    repeat (5) @(posedge clk);
    #1;
    chk("bp count", got.size(), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      chk($sformatf("bp res %0d", i), got[i].res, 32'd200 + i);
      chk($sformatf("bp tag %0d", i), {27'd0, got[i].tag}, 32'd10 + i);
    end

    // ---- reset with 2 entries in flight ----
    got.delete();
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 2; c++) begin
      drive(7'b0110011, 3'b000, 1'b0, 32'd1, 32'd1, 32'd0, 5'(20 + c));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("inflight out_valid", {31'd0, out_valid}, 32'd1);
    chk("inflight in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("async rst result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post rst no outputs", got.size(), 32'd0);
    chk("post rst in_ready", {31'd0, in_ready}, 32'd1);
    if (k != 0) $display("unexpected");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so a stuck run still ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ex_alu_issue.md
Name: ex_alu_issue

Overview:
- Execute-stage front end that drives the ALU control/operand interface; it is the producer side of the ALU's `ctr`/`dataA`/`dataB` inputs and the consumer of its `out`/`zero` outputs.
- Takes decoded instruction fields from ID with a valid/ready handshake and registers them into an issue register (S1).
- The S1 register drives the combinational ALU.
- Captures the ALU result and zero flag into a result register (S2), which feeds MEM/WB with its own valid/ready handshake.

Parameters:
- XLEN, 32, datapath width
- TAG_W, 5, width of the passthrough tag (rd index)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ID presents an instruction
- in_ready  out  1  block accepts an instruction this cycle
- opcode  in  7  RV32I opcode
- funct3  in  3  RV32I funct3
- funct7b5  in  1  instr[30]
- rs1_data  in  XLEN  source operand 1
- rs2_data  in  XLEN  source operand 2
- imm  in  XLEN  sign-extended immediate
- tag_in  in  TAG_W  destination tag
- alu_ctr  out  2  ALU control: AND=2'b00, OR=2'b01, ADD=2'b10, SUB=2'b11
- alu_a  out  XLEN  ALU operand A
- alu_b  out  XLEN  ALU operand B
- alu_out  in  XLEN  ALU result (combinational from alu_ctr/alu_a/alu_b)
- alu_zero  in  1  ALU result == 0
- out_valid  out  1  S2 holds a result
- out_ready  in  1  downstream accepts the result
- result  out  XLEN  registered ALU result
- br_taken  out  1  branch resolved taken
- is_branch  out  1  S2 entry is a branch
- illegal  out  1  S2 entry had an unsupported encoding
- tag_out  out  TAG_W  registered tag

Behaviour:
- Reset (async, rst_n=0): S1 and S2 valid flags clear; all S1/S2 data registers clear to 0.
  - Outputs: out_valid=0, result=0, br_taken=0, is_branch=0, illegal=0, tag_out=0, alu_ctr=2'b10 (ADD), alu_a=0, alu_b=0.
  - in_ready=1 from the first cycle after reset deasserts.
- Advance rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational).
  - Accept = in_valid && in_ready.
- S1 load: on accept, S1 captures decoded ctr, A, B, kind, illegal and tag, and sets s1_valid.
  - If s1_adv is true without an accept, s1_valid clears.
  - If s1_adv is false, S1 holds.
- S2 load: when s1_adv && s1_valid, S2 captures alu_out, the zero-derived br_taken, is_branch, illegal and tag, and sets s2_valid.
  - If s2_adv is true and S1 is empty, s2_valid clears.
  - If s2_adv is false, S2 holds.
- Latency and throughput: 2 cycles from accept to out_valid. Full throughput, 1 op/cycle, when out_ready is held high.
- Backpressure: with out_ready=0 the block absorbs exactly 2 entries, then drops in_ready. While stalled, S2 outputs and alu_* stay stable.
- Decode, always operand A = rs1_data:
  - 0110011 R-type:
    - f3=000 with f7b5=0 → ADD; with f7b5=1 → SUB.
    - f3=110 → OR.
    - f3=111 → AND.
    - B=rs2.
  - 0010011 I-type: f3=000 → ADD, 110 → OR, 111 → AND; B=imm. funct7b5 is ignored.
  - 0000011 load / 0100011 store: ADD, B=imm (effective address).
  - 1100011 branch: SUB, B=rs2, kind=branch.
    - f3=000 (BEQ): br_taken = alu_zero.
    - f3=001 (BNE): br_taken = !alu_zero.
  - Any other opcode/funct combination: illegal=1, ctr=ADD, A=0, B=0, result=0, br_taken=0. The entry still flows through the pipe; no exception is raised here.
- br_taken and is_branch are 0 for all non-branch kinds.
- Arithmetic: XLEN-bit modulo; the carry out is discarded. SUB of equal operands gives result=0 and zero=1.
- Simultaneous events:
  - Accept while S1 moves to S2 in the same cycle: both happen, with no bubble.
  - out_ready drop while S1 is full: both S1 and S2 hold and in_ready=0.
- Reset mid-operation: in-flight entries are discarded with no output handshake.

Test Plan:
- Reset, then ADD R-type rs1=5, rs2=7 in cycle 0 → out_valid in cycle 2, result=12, illegal=0, is_branch=0.
- SUB rs1=3, rs2=5 → result=0xFFFFFFFE. ADDI 0xFFFFFFFF+1 → result=0 (wrap-around).
- BEQ with rs1=rs2=0x1234 → br_taken=1, result=0. BNE with the same operands → br_taken=0. BNE 1 vs 2 → br_taken=1.
- Back-to-back stream of 8 ops with out_ready=1 → 8 results on consecutive cycles, in order, with tags 0..7 preserved.
- Hold out_ready=0 and offer 4 ops → exactly 2 are accepted, then in_ready=0. Raise out_ready → the remaining ops complete in order with no loss or duplication.
- opcode 0110011 with f3=001 (SLL) → illegal=1, result=0. Assert rst_n=0 while 2 entries are in flight → out_valid=0 immediately and both entries are discarded.
